// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encoding and values, credit FSM states,
// and the default item prices used by both the purchase and credit managers.
package vend_pkg;

    localparam logic [1:0] NICKEL  = 2'b00;
    localparam logic [1:0] DIME    = 2'b01;
    localparam logic [1:0] QUARTER = 2'b10;
    localparam logic [1:0] DOLLAR  = 2'b11;

    localparam logic [7:0] VAL_NICKEL  = 8'd5;
    localparam logic [7:0] VAL_DIME    = 8'd10;
    localparam logic [7:0] VAL_QUARTER = 8'd25;
    localparam logic [7:0] VAL_DOLLAR  = 8'd100;

    localparam logic [7:0] DEF_PRICE_APPLE  = 8'd75;
    localparam logic [7:0] DEF_PRICE_BANANA = 8'd20;
    localparam logic [7:0] DEF_PRICE_CARROT = 8'd30;
    localparam logic [7:0] DEF_PRICE_DATE   = 8'd40;

    typedef enum logic {
        IDLE,
        CHANGE
    } state_e;

    function automatic logic [7:0] coin_value(input logic [1:0] coin);
        case (coin)
            NICKEL:  return VAL_NICKEL;
            DIME:    return VAL_DIME;
            QUARTER: return VAL_QUARTER;
            DOLLAR:  return VAL_DOLLAR;
            default: return VAL_NICKEL;
        endcase
    endfunction

endpackage

// File: rtl/credit_mngr_if.sv
// Coin-in, dispense, refund and change-return signals of the credit manager.
// The master side is the vending environment; the slave side is credit_mngr.
interface credit_mngr_if;

    logic       coin_valid;
    logic [1:0] coin_type;
    logic       apple;
    logic       banana;
    logic       carrot;
    logic       date;
    logic       refund;
    logic       change_ack;
    logic [7:0] credit;
    logic       coin_reject;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       busy;

    modport master (
        output coin_valid, coin_type, apple, banana, carrot, date, refund, change_ack,
        input  credit, coin_reject, change_valid, change_coin, busy
    );

    modport slave (
        input  coin_valid, coin_type, apple, banana, carrot, date, refund, change_ack,
        output credit, coin_reject, change_valid, change_coin, busy
    );

endinterface

// File: rtl/change_sel.sv
// Greedy change picker: largest returnable coin (quarter, dime, nickel) that
// fits in the current credit. Dollars are never paid back.
module change_sel
    import vend_pkg::*;
(
    input  logic [7:0] credit_i,
    output logic [1:0] coin_o,
    output logic [7:0] value_o
);

    // NOTE: defaults are assigned first so no path through this block infers a latch.
    always_comb begin
        coin_o  = NICKEL;
        value_o = VAL_NICKEL;
        if (credit_i >= VAL_QUARTER) begin
            coin_o  = QUARTER;
            value_o = VAL_QUARTER;
        end else if (credit_i >= VAL_DIME) begin
            coin_o  = DIME;
            value_o = VAL_DIME;
        end
    end

endmodule

// File: rtl/credit_mngr.sv
// Credit manager: accumulates coins, charges dispensed items on their rising
// edge and pays change or refunds back one coin per valid/ack handshake.
module credit_mngr
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE_APPLE  = DEF_PRICE_APPLE,
    parameter logic [7:0] PRICE_BANANA = DEF_PRICE_BANANA,
    parameter logic [7:0] PRICE_CARROT = DEF_PRICE_CARROT,
    parameter logic [7:0] PRICE_DATE   = DEF_PRICE_DATE,
    parameter logic [7:0] MAX_CREDIT   = 8'd200
) (
    input  logic         clk,
    input  logic         reset,
    credit_mngr_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [3:0] hist_q, hist_d;
    logic       reject_q, reject_d;

    logic [3:0] rise;
    logic [7:0] price;
    logic [8:0] coin_sum;
    logic [1:0] sel_coin;
    logic [7:0] sel_value;

    change_sel u_change_sel (
        .credit_i (credit_q),
        .coin_o   (sel_coin),
        .value_o  (sel_value)
    );

    // Bit order {apple, banana, carrot, date} doubles as the charge priority.
    assign hist_d   = {bus.apple, bus.banana, bus.carrot, bus.date};
    assign rise     = hist_d & ~hist_q;
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type)};

    always_comb begin
        price = PRICE_DATE;
        if (rise[3])      price = PRICE_APPLE;
        else if (rise[2]) price = PRICE_BANANA;
        else if (rise[1]) price = PRICE_CARROT;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    reject_d = bus.coin_valid;
                    if (credit_q >= price) begin
                        credit_d = credit_q - price;
                        if (credit_q != price) state_d = CHANGE;
                    end
                end else if (bus.refund && (credit_q != '0)) begin
                    reject_d = bus.coin_valid;
                    state_d  = CHANGE;
                end else if (bus.coin_valid) begin
                    if (coin_sum <= {1'b0, MAX_CREDIT}) credit_d = coin_sum[7:0];
                    else                                reject_d = 1'b1;
                end
            end
            CHANGE: begin
                reject_d = bus.coin_valid;
                if (bus.change_ack) begin
                    credit_d = credit_q - sel_value;
                    if (credit_q == sel_value) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            hist_q   <= '1;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            hist_q   <= hist_d;
            reject_q <= reject_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.coin_reject  = reject_q;
    assign bus.change_valid = (state_q == CHANGE);
    assign bus.busy         = (state_q == CHANGE);
    assign bus.change_coin  = sel_coin;

endmodule

// File: tb/tb_credit_mngr.sv
// Bench for credit_mngr: directed scenarios then random traffic, every cycle
// compared against a model that tracks credit and the queue of change coins owed.
module tb_credit_mngr;

    logic clk;
    logic reset;

    credit_mngr_if bus ();

    credit_mngr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: credit in cents, the coins still to be paid out, last reject, last dispense levels.
    int         m_credit;
    int         m_owed[$];
    logic       m_reject;
    logic [3:0] m_prev;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int value_of(input logic [1:0] t);
        case (t)
            2'b00:   return 5;
            2'b01:   return 10;
            2'b10:   return 25;
            default: return 100;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int v);
        if (v == 25) return 2'b10;
        if (v == 10) return 2'b01;
        return 2'b00;
    endfunction

    task automatic load_change(input int amount);
        int c;
        c = amount;
        m_owed.delete();
        while (c >= 25) begin m_owed.push_back(25); c -= 25; end
        while (c >= 10) begin m_owed.push_back(10); c -= 10; end
        while (c >= 5)  begin m_owed.push_back(5);  c -= 5;  end
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic model_step();
        logic [3:0] lines;
        logic [3:0] rises;
        logic       rej;
        int         price;
        int         val;
        lines = {bus.apple, bus.banana, bus.carrot, bus.date};
        rises = lines & ~m_prev;
        rej   = 1'b0;
        if (m_owed.size() != 0) begin
            rej = bus.coin_valid;
            if (bus.change_ack) begin
                m_credit -= m_owed[0];
                void'(m_owed.pop_front());
            end
        end else if (rises != 4'b0000) begin
            if (rises[3])      price = 75;
            else if (rises[2]) price = 20;
            else if (rises[1]) price = 30;
            else               price = 40;
            if (m_credit >= price) begin
                m_credit -= price;
                load_change(m_credit);
            end
            rej = bus.coin_valid;
        end else if (bus.refund && m_credit > 0) begin
            load_change(m_credit);
            rej = bus.coin_valid;
        end else if (bus.coin_valid) begin
            val = value_of(bus.coin_type);
            if (m_credit + val <= 200) m_credit += val;
            else                       rej = 1'b1;
        end
        m_reject = rej;
        m_prev   = lines;
    endtask

    task automatic compare_all();
        check("credit", 16'(bus.credit), 16'(m_credit));
        check("busy", 16'(bus.busy), 16'(m_owed.size() != 0));
        check("change_valid", 16'(bus.change_valid), 16'(m_owed.size() != 0));
        check("coin_reject", 16'(bus.coin_reject), 16'(m_reject));
        if (m_owed.size() != 0)
            check("change_coin", 16'(bus.change_coin), 16'(code_of(m_owed[0])));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_credit = 0;
        m_owed.delete();
        m_reject = 1'b0;
        m_prev   = 4'b1111;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        bus.coin_valid = 1'b1;
        bus.coin_type  = t;
        cyc();
        bus.coin_valid = 1'b0;
    endtask

    task automatic ack_after(input int delay);
        for (int i = 0; i < delay; i++) cyc();
        bus.change_ack = 1'b1;
        cyc();
        bus.change_ack = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'b00;
        bus.apple      = 1'b0;
        bus.banana     = 1'b0;
        bus.carrot     = 1'b0;
        bus.date       = 1'b0;
        bus.refund     = 1'b0;
        bus.change_ack = 1'b0;

        // Scenario 1: 3 quarters + dime, apple held three cycles, one charge.
        do_reset();
        check("rst_credit", 16'(bus.credit), 16'd0);
        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01);
        check("s1_credit85", 16'(bus.credit), 16'd85);
        bus.apple = 1'b1;
        cyc();
        check("s1_after_apple", 16'(bus.credit), 16'd10);
        check("s1_coin_dime", 16'(bus.change_coin), 16'd1);
        cyc(); cyc();
        check("s1_single_charge", 16'(bus.credit), 16'd10);
        bus.apple = 1'b0;
        ack_after(0);
        check("s1_done", 16'(bus.busy), 16'd0);

        // Scenario 2: dollar refunded as four quarters with mixed ack delays.
        coin(2'b11);
        bus.refund = 1'b1;
        cyc();
        bus.refund = 1'b0;
        check("s2_refund_coin", 16'(bus.change_coin), 16'd2);
        ack_after(0); ack_after(3); ack_after(0); ack_after(3);
        check("s2_credit0", 16'(bus.credit), 16'd0);
        check("s2_idle", 16'(bus.busy), 16'd0);

        // Scenario 3: ceiling reached, nickel bounced for exactly one cycle.
        coin(2'b11); coin(2'b11);
        coin(2'b00);
        check("s3_reject", 16'(bus.coin_reject), 16'd1);
        check("s3_credit200", 16'(bus.credit), 16'd200);
        cyc();
        check("s3_reject_gone", 16'(bus.coin_reject), 16'd0);

        // Scenario 4: banana edge and dime in the same cycle.
        do_reset();
        coin(2'b10); coin(2'b00);
        bus.banana     = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_type  = 2'b01;
        cyc();
        bus.coin_valid = 1'b0;
        check("s4_reject", 16'(bus.coin_reject), 16'd1);
        check("s4_credit10", 16'(bus.credit), 16'd10);
        bus.banana = 1'b0;
        ack_after(1);

        // Scenario 5: coins and carrot edge during CHANGE have no effect.
        coin(2'b11);
        bus.date = 1'b1;
        cyc();
        check("s5_credit60", 16'(bus.credit), 16'd60);
        coin(2'b10);
        check("s5_reject", 16'(bus.coin_reject), 16'd1);
        bus.carrot = 1'b1;
        cyc(); cyc();
        check("s5_no_carrot", 16'(bus.credit), 16'd60);
        ack_after(0); ack_after(2); ack_after(0);
        bus.carrot = 1'b0;
        bus.date   = 1'b0;
        cyc();

        // Scenario 6: reset mid-CHANGE at 35 cents, date held through reset.
        coin(2'b11); coin(2'b01);
        bus.apple = 1'b1;
        cyc();
        bus.apple = 1'b0;
        check("s6_credit35", 16'(bus.credit), 16'd35);
        bus.date = 1'b1;
        cyc();
        do_reset();
        check("s6_rst_cv", 16'(bus.change_valid), 16'd0);
        coin(2'b11);
        cyc(); cyc();
        check("s6_date_not_charged", 16'(bus.credit), 16'd100);
        bus.date = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bus.coin_valid = ($urandom_range(0, 9) < 3);
            bus.coin_type  = 2'($urandom_range(0, 3));
            bus.refund     = ($urandom_range(0, 19) == 0);
            bus.change_ack = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) bus.apple  = ~bus.apple;
            if ($urandom_range(0, 9) == 0) bus.banana = ~bus.banana;
            if ($urandom_range(0, 9) == 0) bus.carrot = ~bus.carrot;
            if ($urandom_range(0, 9) == 0) bus.date   = ~bus.date;
            if ($urandom_range(0, 299) == 0) do_reset();
            else                             cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_mngr.md
# credit_mngr

Credit-side counterpart of the vending purchase manager. It accumulates inserted coins into the 8-bit `credit` value that the purchase manager compares against prices. When it sees a dispense (`apple`/`banana`/`carrot`/`date`) it deducts the price and returns the remaining credit as change. On a refund request it returns the whole credit. Change goes out one coin at a time over a valid/ack handshake to the coin-return mechanism.

## Interface
Parameters:
- PRICE_APPLE, 75, apple price in cents
- PRICE_BANANA, 20, banana price in cents
- PRICE_CARROT, 30, carrot price in cents
- PRICE_DATE, 40, date price in cents
- MAX_CREDIT, 200, credit ceiling in cents; must be a multiple of 5 and ≤255

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle strobe: coin inserted
- coin_type  in  2  00 nickel (5), 01 dime (10), 10 quarter (25), 11 dollar (100)
- apple, banana, carrot, date  in  1 each  dispense levels from the purchase manager
- refund  in  1  level or pulse: return all credit
- change_ack  in  1  coin-return has taken the presented coin
- credit  out  8  current credit in cents, registered
- coin_reject  out  1  one-cycle pulse: inserted coin returned unaccepted
- change_valid  out  1  a change coin is presented
- change_coin  out  2  coin presented; same encoding as coin_type, never 11
- busy  out  1  high while in CHANGE

## Operation
- States: IDLE and CHANGE.
- Reset values: all outputs 0 and state IDLE. Dispense-history registers reset to 1, so a line already held high through reset is not charged.
- A dispense event is a rising edge on a dispense line (line high, history low). History registers update every cycle.
- IDLE, priority per cycle:
  1. Dispense event. Apple > banana > carrot > date if several rise together. If credit ≥ price: credit ← credit − price. Then go to CHANGE if the result is nonzero, otherwise stay in IDLE. If credit < price: no-op.
  2. Refund high with credit ≠ 0: go to CHANGE, credit unchanged.
  3. coin_valid: if credit + value ≤ MAX_CREDIT, credit ← credit + value. Otherwise pulse coin_reject and leave credit unchanged.
- Any coin_valid in a cycle where priority 1 or 2 fires is rejected (coin_reject).
- CHANGE: change_coin is the greedy choice. Quarter if credit ≥ 25, else dime if ≥ 10, else nickel. Dollars are never returned.
  - On change_ack: credit ← credit − coin value. Go to IDLE when the new credit is 0.
  - In CHANGE, every coin_valid is rejected, and dispense events and refund are ignored.
- Arithmetic: compute the coin sum 9 bits wide before comparing against MAX_CREDIT; no wrap. Credit is always a multiple of 5, so there is never a sub-nickel residue.

## Timing
- Coin accept: credit updates on the edge after the coin_valid cycle (1-cycle latency).
- Coin reject: coin_reject is high for exactly the one cycle after the rejected coin_valid.
- Dispense edge in cycle N: updated credit, busy and change_valid are all visible in cycle N+1.
- change_valid, change_coin and credit are held stable until change_ack. On an ack in cycle M, the next coin (or IDLE, with change_valid low) appears in M+1.
- Back-to-back acks every cycle are legal. change_ack while change_valid is low is ignored.
- Reset mid-CHANGE: credit 0, change_valid 0 and busy 0 on the next cycle. The pending coin is abandoned.

## Structure
- Shared package vend_pkg holds:
  - coin encoding constants (NICKEL, DIME, QUARTER, DOLLAR)
  - coin value constants (5/10/25/100)
  - the state enum (IDLE, CHANGE)
  - default price constants, which the purchase manager also uses
- Sub-module change_sel: combinational greedy picker. Input 8-bit credit; outputs the 2-bit coin and its 8-bit value. It is instantiated once and its value is shared by the ack-subtract path.

## Test plan
1. Reset, insert 3×quarter + dime → credit 85. Hold apple high 3 cycles → credit 10 next cycle, change_valid=1, change_coin=01. Ack → credit 0, IDLE; exactly one deduction.
2. Insert dollar → credit 100. Pulse refund → four quarters presented, with ack delays of 0 and 3 cycles. change_coin stays stable until each ack; ends with credit 0 and busy 0.
3. Two dollars → credit 200. Nickel → coin_reject pulses one cycle, credit stays 200.
4. Credit 30, banana rising edge and dime coin_valid in the same cycle → coin_reject=1, credit 10, one dime of change.
5. During CHANGE: quarter inserted → rejected; carrot edge → ignored; credit decreases only on acks.
6. Reset asserted mid-CHANGE with credit 35 → next cycle credit 0, change_valid 0. Date held high across reset is not charged.
